// File: rtl/cpu_control_unit.sv
// Multi-cycle controller for the 8-bit accumulator CPU.
// It owns the program counter and latches the instruction returned by
// Instruction_Memory. It sequences data-memory strobes, the accumulator
// load and ALU selection. Strobes are Moore outputs decoded from State.
module cpu_control_unit #(
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [2:0]            Opcode,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  Acc_zero,
  input  logic                  Run,
  output logic [ADDR_WIDTH-1:0] Program_counter,
  output logic [ADDR_WIDTH-1:0] Mem_addr,
  output logic                  Mem_rd,
  output logic                  Mem_wr,
  output logic                  Acc_ld,
  output logic [2:0]            Alu_op,
  output logic                  Halted,
  output logic [2:0]            State
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] READ   = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

  logic [2:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [2:0]            ir_op;
  logic [ADDR_WIDTH-1:0] ir_addr;

  // Next-state and next-PC decode; PC wraps naturally at 2^ADDR_WIDTH.
  always_comb begin
    state_nxt = FETCH;
    pc_nxt    = pc;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (Opcode)
          OP_HLT: state_nxt = HALT;
          OP_SKZ: begin
            state_nxt = FETCH;
            pc_nxt    = pc + (Acc_zero ? PC_TWO : PC_ONE);
          end
          OP_JMP: begin
            state_nxt = FETCH;
            pc_nxt    = Address;
          end
          OP_STO: state_nxt = WRITE;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: state_nxt = READ;
          default: state_nxt = FETCH;
        endcase
      end
      READ:   state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc + PC_ONE;
      end
      WRITE: begin
        state_nxt = FETCH;
        pc_nxt    = pc + PC_ONE;
      end
      HALT: begin
        if (Run) begin
          state_nxt = FETCH;
          pc_nxt    = pc + PC_ONE;
        end else begin
          state_nxt = HALT;
        end
      end
      // Unused encodings recover to FETCH.
      default: state_nxt = FETCH;
    endcase
  end

  // State and PC registers, asynchronously reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Instruction latch: captured only in DECODE so Mem_addr/Alu_op stay
  // stable for the rest of the instruction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_op   <= '0;
      ir_addr <= '0;
    end else if (state == DECODE) begin
      ir_op   <= Opcode;
      ir_addr <= Address;
    end
  end

  assign Program_counter = pc;
  assign State           = state;
  assign Mem_addr        = ir_addr;
  assign Alu_op          = ir_op;
  assign Mem_rd          = (state == READ);
  assign Mem_wr          = (state == WRITE);
  assign Acc_ld          = (state == EXEC);
  assign Halted          = (state == HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: models Instruction_Memory as a
// registered lookup of Program_counter and checks a per-cycle vector
// table plus hand-written reset/halt/wrap sequences.
module tb_cpu_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] Opcode;
  logic [4:0] Address;
  logic       Acc_zero;
  logic       Run;
  logic [4:0] Program_counter;
  logic [4:0] Mem_addr;
  logic       Mem_rd, Mem_wr, Acc_ld, Halted;
  logic [2:0] Alu_op;
  logic [2:0] State;

  cpu_control_unit #(.ADDR_WIDTH(5), .RESET_PC(5'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Address(Address),
    .Acc_zero(Acc_zero), .Run(Run), .Program_counter(Program_counter),
    .Mem_addr(Mem_addr), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Acc_ld(Acc_ld),
    .Alu_op(Alu_op), .Halted(Halted), .State(State)
  );

  always #5 Clk = ~Clk;

  // Instruction memory: {opcode, address}, registered read of the PC.
  logic [7:0] imem [32];
  always @(posedge Clk) {Opcode, Address} <= imem[Program_counter];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  // One cycle of a hand sequence: drive inputs, check, advance to next negedge.
  task automatic cyc(input string nm, input int idx, input logic run, input logic az,
                     input logic [2:0] st, input logic [4:0] pc, input logic hl, input logic ld);
    Run = run; Acc_zero = az;
    #1;
    chk({nm, ".state"}, idx, 8'(State), 8'(st));
    chk({nm, ".pc"}, idx, 8'(Program_counter), 8'(pc));
    chk({nm, ".halted"}, idx, 8'(Halted), 8'(hl));
    chk({nm, ".acc_ld"}, idx, 8'(Acc_ld), 8'(ld));
    @(negedge Clk);
  endtask

  // Hold reset over two edges; the caller loads imem meanwhile.
  task automatic reset_hold();
    Reset = 1'b1; Run = 1'b0; Acc_zero = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  typedef struct {
    logic       run, az;
    logic [2:0] st;
    logic [4:0] pc, maddr;
    logic [2:0] alu;
    logic       rd, wr, ld, hl;
  } vec_t;

  vec_t v [23];

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 8'h00;
    imem[0]  = {3'd5, 5'd5};   // LDA 5
    imem[1]  = {3'd6, 5'd6};   // STO 6
    imem[2]  = {3'd1, 5'd0};   // SKZ (not taken)
    imem[3]  = {3'd7, 5'd17};  // JMP 17
    imem[17] = {3'd7, 5'd4};   // JMP 4
    imem[4]  = {3'd1, 5'd0};   // SKZ (taken)
    imem[6]  = {3'd7, 5'd9};   // JMP 9
    imem[9]  = {3'd0, 5'd0};   // HLT
    imem[10] = {3'd2, 5'd7};   // ADD 7

    //       run az st  pc  ma alu rd wr ld hl
    v[0]  = '{0, 0, 0,  0,  0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 0, 1,  0,  0, 0, 0, 0, 0, 0};
    v[2]  = '{0, 0, 2,  0,  5, 5, 1, 0, 0, 0};
    v[3]  = '{0, 0, 3,  0,  5, 5, 0, 0, 1, 0};
    v[4]  = '{0, 0, 0,  1,  5, 5, 0, 0, 0, 0};
    v[5]  = '{0, 0, 1,  1,  5, 5, 0, 0, 0, 0};
    v[6]  = '{0, 0, 4,  1,  6, 6, 0, 1, 0, 0};
    v[7]  = '{0, 0, 0,  2,  6, 6, 0, 0, 0, 0};
    v[8]  = '{0, 0, 1,  2,  6, 6, 0, 0, 0, 0};
    v[9]  = '{0, 1, 0,  3,  0, 1, 0, 0, 0, 0};
    v[10] = '{0, 1, 1,  3,  0, 1, 0, 0, 0, 0};
    v[11] = '{0, 0, 0, 17, 17, 7, 0, 0, 0, 0};
    v[12] = '{0, 0, 1, 17, 17, 7, 0, 0, 0, 0};
    v[13] = '{0, 0, 0,  4,  4, 7, 0, 0, 0, 0};
    v[14] = '{0, 1, 1,  4,  4, 7, 0, 0, 0, 0};
    v[15] = '{0, 0, 0,  6,  0, 1, 0, 0, 0, 0};
    v[16] = '{1, 0, 1,  6,  0, 1, 0, 0, 0, 0};
    v[17] = '{1, 0, 0,  9,  9, 7, 0, 0, 0, 0};
    v[18] = '{1, 0, 1,  9,  9, 7, 0, 0, 0, 0};
    v[19] = '{0, 0, 5,  9,  0, 0, 0, 0, 0, 1};
    v[20] = '{0, 0, 5,  9,  0, 0, 0, 0, 0, 1};
    v[21] = '{1, 0, 5,  9,  0, 0, 0, 0, 0, 1};
    v[22] = '{0, 0, 0, 10,  0, 0, 0, 0, 0, 0};

    // Reset held for three cycles; outputs checked while held.
    Reset = 1'b1; Run = 1'b0; Acc_zero = 1'b0;
    #1;
    chk("rst.state", 0, 8'(State), 8'd0);
    chk("rst.pc", 0, 8'(Program_counter), 8'd0);
    chk("rst.strobes", 0, 8'({Mem_rd, Mem_wr, Acc_ld, Halted}), 8'd0);
    chk("rst.maddr", 0, 8'(Mem_addr), 8'd0);
    chk("rst.alu", 0, 8'(Alu_op), 8'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Main program, one vector per cycle.
    for (int i = 0; i < 23; i++) begin
      Run = v[i].run; Acc_zero = v[i].az;
      #1;
      chk("state", i, 8'(State), 8'(v[i].st));
      chk("pc", i, 8'(Program_counter), 8'(v[i].pc));
      chk("mem_addr", i, 8'(Mem_addr), 8'(v[i].maddr));
      chk("alu_op", i, 8'(Alu_op), 8'(v[i].alu));
      chk("strobes", i, 8'({Mem_rd, Mem_wr, Acc_ld, Halted}),
          8'({v[i].rd, v[i].wr, v[i].ld, v[i].hl}));
      @(negedge Clk);
    end

    // ADD at PC 10: reset lands in READ, strobe must drop immediately.
    cyc("add", 0, 0, 0, 1, 10, 0, 0);
    Run = 1'b0; Acc_zero = 1'b0;
    #1;
    chk("add.rd", 1, 8'(Mem_rd), 8'd1);
    chk("add.maddr", 1, 8'(Mem_addr), 8'd7);
    Reset = 1'b1;
    #1;
    chk("midrst.rd", 0, 8'(Mem_rd), 8'd0);
    chk("midrst.state", 0, 8'(State), 8'd0);
    chk("midrst.pc", 0, 8'(Program_counter), 8'd0);
    @(negedge Clk);
    imem[0] = {3'd7, 5'd9};    // JMP 9
    reset_hold();
    Reset = 1'b0;
    cyc("postrst", 0, 0, 0, 0, 0, 0, 0);
    cyc("postrst", 1, 0, 0, 1, 0, 0, 0);
    cyc("postrst", 2, 0, 0, 0, 9, 0, 0);
    cyc("postrst", 3, 0, 0, 1, 9, 0, 0);

    // HLT holds for 10 cycles with Run low, then a Run pulse resumes.
    for (int i = 0; i < 10; i++) cyc("halt", i, 0, 0, 5, 9, 1, 0);
    cyc("halt", 10, 1, 0, 5, 9, 1, 0);
    cyc("resume", 0, 0, 0, 0, 10, 0, 0);

    // PC wrap: SKZ taken at 31 -> 1, at 30 -> 0, not taken at 31 -> 0.
    imem[0]  = {3'd7, 5'd31};  // JMP 31
    imem[31] = {3'd1, 5'd0};   // SKZ
    imem[1]  = {3'd7, 5'd30};  // JMP 30
    imem[30] = {3'd1, 5'd0};   // SKZ
    reset_hold();
    Reset = 1'b0;
    cyc("wrap", 0, 0, 0, 0, 0, 0, 0);
    cyc("wrap", 1, 0, 0, 1, 0, 0, 0);
    cyc("wrap", 2, 0, 0, 0, 31, 0, 0);
    cyc("wrap", 3, 0, 1, 1, 31, 0, 0);
    cyc("wrap", 4, 0, 0, 0, 1, 0, 0);
    cyc("wrap", 5, 0, 0, 1, 1, 0, 0);
    cyc("wrap", 6, 0, 0, 0, 30, 0, 0);
    cyc("wrap", 7, 0, 1, 1, 30, 0, 0);
    cyc("wrap", 8, 0, 0, 0, 0, 0, 0);
    cyc("wrap", 9, 0, 0, 1, 0, 0, 0);
    cyc("wrap", 10, 0, 1, 0, 31, 0, 0);
    cyc("wrap", 11, 0, 0, 1, 31, 0, 0);
    cyc("wrap", 12, 0, 0, 0, 0, 0, 0);

    // EXEC increment wraps 31 -> 0.
    imem[31] = {3'd5, 5'd3};   // LDA 3
    reset_hold();
    Reset = 1'b0;
    cyc("exwrap", 0, 0, 0, 0, 0, 0, 0);
    cyc("exwrap", 1, 0, 0, 1, 0, 0, 0);
    cyc("exwrap", 2, 0, 0, 0, 31, 0, 0);
    cyc("exwrap", 3, 0, 0, 1, 31, 0, 0);
    cyc("exwrap", 4, 0, 0, 2, 31, 0, 0);
    cyc("exwrap", 5, 0, 0, 3, 31, 0, 1);
    cyc("exwrap", 6, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
